// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
// Shared definitions for the vector register file with scoreboard:
//   - default sizing constants (lane width, register index width, lanes/vector)
//   - the bulk-clear FSM state encoding
// -----------------------------------------------------------------------------
package vrf_pkg;

  localparam int VRF_DATA_WIDTH = 16;
  localparam int VRF_REG_WIDTH  = 4;
  localparam int VRF_VMAX       = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vrf_state_e;

endpackage

// File: rtl/vrf_scoreboard.sv
// -----------------------------------------------------------------------------
// vrf_scoreboard
// One busy bit per architectural register. A register becomes busy when a
// reservation is granted and is released by any accepted write to it.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   idle_i               register file FSM is in IDLE
//   clr_all_i            drop every busy bit at the next edge (entering CLEAR)
//   wen_i, rd_i          write strobe / destination (releases busy)
//   rsv_i, rsv_rd_i      reservation request / target
//   rsv_ok_o             reservation granted (combinational)
//   rs1_i, rs2_i         source indices
//   rs1_ready_o, rs2_ready_o  source not pending (combinational)
// -----------------------------------------------------------------------------
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int REG_WIDTH = VRF_REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 idle_i,
  input  logic                 clr_all_i,
  input  logic                 wen_i,
  input  logic [REG_WIDTH-1:0] rd_i,
  input  logic                 rsv_i,
  input  logic [REG_WIDTH-1:0] rsv_rd_i,
  output logic                 rsv_ok_o,
  input  logic [REG_WIDTH-1:0] rs1_i,
  input  logic [REG_WIDTH-1:0] rs2_i,
  output logic                 rs1_ready_o,
  output logic                 rs2_ready_o
);

  localparam int NREG = 2 ** REG_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wen_acc_s;

  // A source is ready if it is r0, or we are idle and it is either not busy
  // or being written this very cycle (its value is bypassed).
  function automatic logic src_ready(input logic [REG_WIDTH-1:0] rs,
                                     input logic [NREG-1:0]      busy,
                                     input logic                 idle,
                                     input logic                 wen,
                                     input logic [REG_WIDTH-1:0] rd);
    return (rs == '0) || (idle && (!busy[rs] || (wen && (rd == rs))));
  endfunction

  assign wen_acc_s   = wen_i && idle_i;
  // The grant looks at the current busy bit only: a release in the same cycle
  // does not forward into a new reservation.
  assign rsv_ok_o    = rsv_i && idle_i && !busy_q[rsv_rd_i];
  assign rs1_ready_o = src_ready(rs1_i, busy_q, idle_i, wen_i, rd_i);
  assign rs2_ready_o = src_ready(rs2_i, busy_q, idle_i, wen_i, rd_i);

  // Next busy vector: clear-all dominates; otherwise release then reserve so a
  // same-cycle write and grant to one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_all_i) begin
      busy_d = '0;
    end else begin
      if (wen_acc_s) begin
        busy_d[rd_i] = 1'b0;
      end
      if (rsv_ok_o) begin
        busy_d[rsv_rd_i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/vector_regfile_sb.sv
// -----------------------------------------------------------------------------
// vector_regfile_sb
// Vector register file (NREG registers of VMAX lanes x DATA_WIDTH bits) with
// lane-masked writes, write-to-read bypass, a busy-bit scoreboard and a
// sequential bulk clear. Register 0 always reads as zero.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   rs1_i/rs2_i                read indices
//   rs1_data_o/rs2_data_o      read data (combinational, bypassed)
//   rs1_ready_o/rs2_ready_o    source not pending
//   wen_i, rd_i, rd_data_i, wmask_i   masked write port
//   rsv_i, rsv_rd_i, rsv_ok_o  destination reservation
//   clr_req_i, clr_busy_o      bulk clear request / in progress
// -----------------------------------------------------------------------------
module vector_regfile_sb
  import vrf_pkg::*;
#(
  parameter int DATA_WIDTH = VRF_DATA_WIDTH,
  parameter int REG_WIDTH  = VRF_REG_WIDTH,
  parameter int VMAX       = VRF_VMAX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REG_WIDTH-1:0]       rs1_i,
  input  logic [REG_WIDTH-1:0]       rs2_i,
  output logic [DATA_WIDTH*VMAX-1:0] rs1_data_o,
  output logic [DATA_WIDTH*VMAX-1:0] rs2_data_o,
  output logic                       rs1_ready_o,
  output logic                       rs2_ready_o,
  input  logic                       wen_i,
  input  logic [REG_WIDTH-1:0]       rd_i,
  input  logic [DATA_WIDTH*VMAX-1:0] rd_data_i,
  input  logic [VMAX-1:0]            wmask_i,
  input  logic                       rsv_i,
  input  logic [REG_WIDTH-1:0]       rsv_rd_i,
  output logic                       rsv_ok_o,
  input  logic                       clr_req_i,
  output logic                       clr_busy_o
);

  localparam int NREG = 2 ** REG_WIDTH;
  localparam int VW   = DATA_WIDTH * VMAX;

  logic [VW-1:0]        regs_q [NREG];
  vrf_state_e           state_q;
  logic [REG_WIDTH-1:0] cnt_q;

  logic                 idle_s;
  logic                 wr_acc_s;
  logic [VW-1:0]        wbits_s;
  logic [VW-1:0]        merged_s;

  assign idle_s     = (state_q == IDLE);
  assign clr_busy_o = (state_q == CLEAR);
  assign wr_acc_s   = wen_i && idle_s && (rd_i != '0);

  // Expand the lane mask to a bit mask and merge new data over the old value.
  always_comb begin
    wbits_s = '0;
    for (int k = 0; k < VMAX; k++) begin
      wbits_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{wmask_i[k]}};
    end
    merged_s = (regs_q[rd_i] & ~wbits_s) | (rd_data_i & wbits_s);
  end

  // Reads: r0 is zero; an accepted write to the same register is bypassed.
  always_comb begin
    if (rs1_i == '0) begin
      rs1_data_o = '0;
    end else if (wr_acc_s && (rd_i == rs1_i)) begin
      rs1_data_o = merged_s;
    end else begin
      rs1_data_o = regs_q[rs1_i];
    end
    if (rs2_i == '0) begin
      rs2_data_o = '0;
    end else if (wr_acc_s && (rd_i == rs2_i)) begin
      rs2_data_o = merged_s;
    end else begin
      rs2_data_o = regs_q[rs2_i];
    end
  end

  // Data array and clear FSM. A write coinciding with clr_req_i still lands;
  // CLEAR then walks r1..rNREG-1 and zeroes one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      state_q <= IDLE;
      cnt_q   <= REG_WIDTH'(1);
    end else begin
      if (wr_acc_s) begin
        regs_q[rd_i] <= merged_s;
      end
      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          regs_q[cnt_q] <= '0;
          if (cnt_q == {REG_WIDTH{1'b1}}) begin
            state_q <= IDLE;
            cnt_q   <= REG_WIDTH'(1);
          end else begin
            cnt_q <= cnt_q + REG_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= REG_WIDTH'(1);
        end
      endcase
    end
  end

  vrf_scoreboard #(
    .REG_WIDTH (REG_WIDTH)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle_i      (idle_s),
    .clr_all_i   (idle_s && clr_req_i),
    .wen_i       (wen_i),
    .rd_i        (rd_i),
    .rsv_i       (rsv_i),
    .rsv_rd_i    (rsv_rd_i),
    .rsv_ok_o    (rsv_ok_o),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rs1_ready_o (rs1_ready_o),
    .rs2_ready_o (rs2_ready_o)
  );

endmodule

// File: doc/vector_regfile_sb.md
VECTOR_REGFILE_SB -- requirements
Module: vector_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, lane width in bits.
REQ-002 SHALL have parameter REG_WIDTH, default 4, register index width; NREG = 2**REG_WIDTH.
REQ-003 SHALL have parameter VMAX, default 8, lanes per vector.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports rs1_i, rs2_i  input  REG_WIDTH  read-port indices.
REQ-007 SHALL have ports rs1_data_o, rs2_data_o  output  DATA_WIDTH*VMAX  read data.
REQ-008 SHALL have ports rs1_ready_o, rs2_ready_o  output  1  source operand not pending.
REQ-009 SHALL have ports wen_i  input  1 write strobe; rd_i  input  REG_WIDTH destination; rd_data_i  input  DATA_WIDTH*VMAX data; wmask_i  input  VMAX lane enables (bit k covers lane k, bits [k*DATA_WIDTH +: DATA_WIDTH]).
REQ-010 SHALL have ports rsv_i  input  1 reserve request; rsv_rd_i  input  REG_WIDTH register to reserve; rsv_ok_o  output  1 reservation granted.
REQ-011 SHALL have ports clr_req_i  input  1 bulk-clear request; clr_busy_o  output  1 clear in progress.

Function
REQ-012 SHALL return all-zero data, ready=1, for reads of register 0; writes and reservations to register 0 SHALL have no state effect, and rsv_ok_o SHALL be 1 for them.
REQ-013 SHALL update, on a rising edge with wen_i=1 and rd_i!=0, only lanes with wmask_i bit set; other lanes keep their value.
REQ-014 SHALL make reads combinational, with bypass: if wen_i=1 and rd_i==rsN_i!=0, rsN_data_o = masked merge of rd_data_i into the stored value in the same cycle.
REQ-015 SHALL keep one busy bit per register (scoreboard); busy[0] SHALL be constant 0.
REQ-016 SHALL assert rsv_ok_o combinationally when rsv_i=1, state IDLE, and busy[rsv_rd_i]=0; a granted reservation sets busy[rsv_rd_i] at the next edge.
REQ-017 SHALL deassert rsv_ok_o when busy[rsv_rd_i]=1, even if that register is released in the same cycle (no release-to-reserve forwarding).
REQ-018 SHALL clear busy[rd_i] on any accepted write (wen_i=1, state IDLE), regardless of wmask_i.
REQ-019 SHALL resolve a same-cycle granted reserve and write to the same non-busy register as: data written, busy set (reserve wins).
REQ-020 SHALL drive rsN_ready_o = 1 when rsN_i==0, or (state IDLE and (busy[rsN_i]=0 or (wen_i=1 and rd_i==rsN_i))).
REQ-021 SHALL implement a two-state FSM IDLE/CLEAR; IDLE->CLEAR on rising edge with clr_req_i=1; CLEAR->IDLE after register NREG-1 is zeroed.
REQ-022 SHALL, in CLEAR, zero one register per cycle, indices 1..NREG-1 ascending via a counter (NREG-1 cycles); all busy bits SHALL clear on the IDLE->CLEAR edge.
REQ-023 SHALL hold clr_busy_o=1 exactly while in CLEAR; in CLEAR, wen_i SHALL be ignored, rsv_ok_o=0, rsN_ready_o=0 for rsN_i!=0, and clr_req_i ignored.
REQ-024 SHALL, when clr_req_i and wen_i/rsv_i coincide in IDLE, accept the write/reservation on that edge and then enter CLEAR (write data is later zeroed, busy cleared).

Reset
REQ-025 SHALL, on rst_n low, asynchronously zero all registers, all busy bits, state=IDLE, counter=1, regardless of operation in progress.
REQ-026 SHALL, during and after reset, present rsN_data_o=0, rsN_ready_o=1, clr_busy_o=0, rsv_ok_o=rsv_i.

Structure
REQ-027 SHALL place FSM state enum (IDLE, CLEAR) and default parameter constants in shared package vrf_pkg.
REQ-028 SHALL implement the busy-bit array and reserve/release/ready logic in sub-module vrf_scoreboard; data array, bypass, and FSM stay in the top.

Verification
REQ-029 Write r3 = 0x0001..0x0008 lanes, mask 0xFF; next cycle write r3 = all 0xFFFF, mask 0x05 -> read r3 lanes 0,2 = 0xFFFF, others unchanged.
REQ-030 Same-cycle write r5 mask 0xFF data 0xAAAA.. with rs1_i=5 -> rs1_data_o = new data in that cycle; rs2_i=0 -> zero.
REQ-031 Reserve r7 -> rsv_ok_o=1; reserve r7 again -> rsv_ok_o=0, rs1_ready_o(r7)=0; write r7 -> ready=1 same cycle; next cycle reserve r7 -> ok=1.
REQ-032 Fill r1..r15 nonzero, pulse clr_req_i -> clr_busy_o high 15 cycles, wen_i/rsv_i ignored meanwhile, all reads zero after, all busy bits clear.
REQ-033 Assert rst_n low at CLEAR cycle 6 -> immediate IDLE, clr_busy_o=0, all registers zero, ready=1.
REQ-034 Write and reserve r9 same cycle (r9 not busy) -> data stored, rsv_ok_o=1, r9 busy next cycle.
